lane_rotator_pipe: RTL and testbench

Parametrised successor to the 4x8 byte-lane rotate stage on BRAM port B. The block accepts read requests, each carrying a lane select and a mode, and delays them by the BRAM read latency so they align with DOUT_B. It rotates, broadcasts or passes the lanes, then buffers the results in a small output FIFO with valid/ready backpressure. It sits between the BRAM read port and downstream consumers that may stall.

---
 rtl/lane_rotator_pipe_pkg.sv | 23 ++
 rtl/lane_rotator_pipe_if.sv | 30 +++
 rtl/lane_rotator_pipe_lane_fifo.sv | 63 ++++++
 rtl/lane_rotator_pipe.sv | 99 +++++++++
 tb/tb_lane_rotator_pipe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_rotator_pipe_pkg.sv
// Shared constants and helpers for the lane rotator pipe and its FIFO.
package lane_rotator_pipe_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_SELECT = clog2(DEF_LANES);

  typedef enum logic [1:0] {
    MODE_LEGACY = 2'd0,
    MODE_ROT    = 2'd1,
    MODE_BCAST  = 2'd2,
    MODE_PASS   = 2'd3
  } mode_e;

endpackage

// File: rtl/lane_rotator_pipe_if.sv
// Request / BRAM data / result handshake bundle for lane_rotator_pipe.
interface lane_rotator_pipe_if
  import lane_rotator_pipe_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W
);
  localparam int SEL_W = clog2(LANES);

  logic                    SM_EN;
  logic                    REQ_VALID;
  logic                    REQ_READY;
  logic [SEL_W-1:0]        REQ_SEL;
  mode_e                   REQ_MODE;
  logic [LANES*LANE_W-1:0] DOUT_B;
  logic [LANES*LANE_W-1:0] OUT_DATA;
  logic                    OUT_VALID;
  logic                    OUT_READY;

  modport master (
    output SM_EN, REQ_VALID, REQ_SEL, REQ_MODE, DOUT_B, OUT_READY,
    input  REQ_READY, OUT_DATA, OUT_VALID
  );

  modport slave (
    input  SM_EN, REQ_VALID, REQ_SEL, REQ_MODE, DOUT_B, OUT_READY,
    output REQ_READY, OUT_DATA, OUT_VALID
  );

endinterface

// File: rtl/lane_rotator_pipe_lane_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// The head register keeps its last value when the FIFO drains.
module lane_fifo
  import lane_rotator_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic [clog2(DEPTH+1)-1:0]  count
);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head;
  logic             do_pop, do_push;

  assign do_pop  = rd_en && (cnt != '0);
  assign do_push = wr_en && ((cnt != CW'(DEPTH)) || do_pop);
  assign wr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  // Storage array; contents need no reset since the head register masks them.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and head word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_next;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (do_pop && (cnt > CW'(1)))
        head <= mem[rd_next];
      else if (do_push && ((cnt == '0) || do_pop))
        head <= wr_data;
    end
  end

  assign rd_data = head;
  assign valid   = (cnt != '0);
  assign count   = cnt;

endmodule

// File: rtl/lane_rotator_pipe.sv
// Aligns lane-select requests with BRAM port-B read data, rotates /
// broadcasts / passes the lanes, and buffers results behind a credit
// check so the output FIFO can never overflow.
module lane_rotator_pipe
  import lane_rotator_pipe_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic           CLK,
  input  logic           RST,
  lane_rotator_pipe_if.slave bus
);
  localparam int SEL_W = clog2(LANES);
  localparam int W     = LANES * LANE_W;
  localparam int FCW   = clog2(FIFO_DEPTH + 1);
  localparam int IW    = clog2(RD_LAT + 1);
  localparam int SW    = clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  // Stage 1 is loaded on the accept edge; stage RD_LAT lines up with DOUT_B.
  logic [RD_LAT:1]  p_vld;
  logic [RD_LAT:1]  p_en;
  logic [SEL_W-1:0] p_sel  [1:RD_LAT];
  mode_e            p_mode [1:RD_LAT];

  logic             accept;
  logic [W-1:0]     result;
  logic [IW-1:0]    inflight;
  logic [FCW-1:0]   fifo_count;
  logic             req_ready;

  assign accept = bus.REQ_VALID && req_ready;

  // Valid bits of the alignment pipe; cleared by reset so late DOUT_B is ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_vld <= '0;
    end else begin
      p_vld[1] <= accept;
      for (int i = 2; i <= RD_LAT; i++) p_vld[i] <= p_vld[i-1];
    end
  end

  // Request attributes ride alongside the valid bits.
  always_ff @(posedge CLK) begin
    p_sel[1]  <= bus.REQ_SEL;
    p_mode[1] <= bus.REQ_MODE;
    p_en[1]   <= bus.SM_EN;
    for (int i = 2; i <= RD_LAT; i++) begin
      p_sel[i]  <= p_sel[i-1];
      p_mode[i] <= p_mode[i-1];
      p_en[i]   <= p_en[i-1];
    end
  end

  // Lane mux on the aligned stage; index arithmetic wraps naturally at LANES.
  always_comb begin
    logic [SEL_W-1:0] idx;
    result = '0;
    idx    = '0;
    for (int k = 0; k < LANES; k++) begin
      case (p_mode[RD_LAT])
        MODE_LEGACY: idx = p_sel[RD_LAT] - SEL_W'(k);
        MODE_ROT:    idx = p_sel[RD_LAT] + SEL_W'(k);
        MODE_BCAST:  idx = p_sel[RD_LAT];
        default:     idx = SEL_W'(k);
      endcase
      result[k*LANE_W +: LANE_W] = bus.DOUT_B[int'(idx)*LANE_W +: LANE_W];
    end
    if (!p_en[RD_LAT]) result = '0;
  end

  // Count requests still travelling the alignment pipe.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LAT; i++) inflight = inflight + IW'(p_vld[i]);
  end

  // Credit: every accepted request already owns a FIFO slot.
  assign req_ready     = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);
  assign bus.REQ_READY = req_ready;

  lane_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (p_vld[RD_LAT]),
    .wr_data (result),
    .rd_en   (bus.OUT_READY),
    .rd_data (bus.OUT_DATA),
    .valid   (bus.OUT_VALID),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_lane_rotator_pipe.sv
// Scoreboard bench for lane_rotator_pipe (LANES=4, LANE_W=8, RD_LAT=1, FIFO_DEPTH=3).
module tb_lane_rotator_pipe;
  import lane_rotator_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lane_rotator_pipe_if #(.LANES(4), .LANE_W(8)) bus ();

  lane_rotator_pipe #(
    .LANES(4), .LANE_W(8), .RD_LAT(1), .FIFO_DEPTH(3)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_data, cur_exp, cap_data, cap_exp;
  logic        cap_acc = 1'b0;
  int          acc_cnt = 0;
  int          cyc = 0;
  bit          stream_on = 1'b0;
  int          drops = 0;
  int          pop_cyc_q[$];

  mode_e       s_mode [0:7];
  logic [1:0]  s_sel  [0:7];
  logic [31:0] s_data [0:7];
  logic [31:0] s_exp  [0:7];

  always @(posedge clk) cyc++;

  // Sample the handshake mid-cycle so the upcoming edge's accept is known.
  always @(negedge clk) begin
    cap_acc  = !rst && bus.REQ_VALID && bus.REQ_READY;
    cap_data = cur_data;
    cap_exp  = cur_exp;
    if (stream_on && bus.REQ_VALID && !bus.REQ_READY) drops++;
  end

  // One-cycle BRAM model: data for an accepted request appears after the accept edge.
  always @(posedge clk) begin
    #1;
    if (cap_acc && !rst) begin
      bus.DOUT_B = cap_data;
      exp_q.push_back(cap_exp);
      acc_cnt++;
    end else begin
      bus.DOUT_B = 32'hDEAD_BEEF;
    end
  end

  // Monitor: every popped word must match the oldest expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && bus.OUT_VALID && bus.OUT_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: got %h but nothing expected", bus.OUT_DATA);
      end else begin
        e = exp_q.pop_front();
        if (bus.OUT_DATA !== e) begin
          errors++;
          $display("FAIL out_word: got %h expected %h", bus.OUT_DATA, e);
        end
      end
      if (stream_on) pop_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic en, input mode_e mode, input logic [1:0] sel,
                      input logic [31:0] data, input logic [31:0] exp);
    int   n;
    logic r;
    bus.SM_EN     = en;
    bus.REQ_MODE  = mode;
    bus.REQ_SEL   = sel;
    cur_data      = data;
    cur_exp       = exp;
    bus.REQ_VALID = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      r = bus.REQ_READY;
      @(posedge clk);
      if (r) break;
      n++;
      if (n >= 40) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept expected accept within 40 cycles");
        break;
      end
    end
    #1;
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    s_mode[0] = MODE_PASS;   s_sel[0] = 2'd0; s_data[0] = 32'h0D0C0B0A; s_exp[0] = 32'h0D0C0B0A;
    s_mode[1] = MODE_ROT;    s_sel[1] = 2'd1; s_data[1] = 32'h0D0C0B0A; s_exp[1] = 32'h0A0D0C0B;
    s_mode[2] = MODE_ROT;    s_sel[2] = 2'd2; s_data[2] = 32'h0D0C0B0A; s_exp[2] = 32'h0B0A0D0C;
    s_mode[3] = MODE_BCAST;  s_sel[3] = 2'd3; s_data[3] = 32'h0D0C0B0A; s_exp[3] = 32'h0D0D0D0D;
    s_mode[4] = MODE_LEGACY; s_sel[4] = 2'd2; s_data[4] = 32'h0D0C0B0A; s_exp[4] = 32'h0D0A0B0C;
    s_mode[5] = MODE_PASS;   s_sel[5] = 2'd1; s_data[5] = 32'hCAFEF00D; s_exp[5] = 32'hCAFEF00D;
    s_mode[6] = MODE_BCAST;  s_sel[6] = 2'd1; s_data[6] = 32'hCAFEF00D; s_exp[6] = 32'hF0F0F0F0;
    s_mode[7] = MODE_LEGACY; s_sel[7] = 2'd3; s_data[7] = 32'hCAFEF00D; s_exp[7] = 32'h0DF0FECA;

    bus.SM_EN     = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_SEL   = 2'd0;
    bus.REQ_MODE  = MODE_PASS;
    bus.DOUT_B    = 32'hDEAD_BEEF;
    bus.OUT_READY = 1'b0;
    cur_data      = '0;
    cur_exp       = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_out_data", bus.OUT_DATA, 0);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", bus.REQ_READY, 1);
    @(posedge clk);
    #1;

    // Latency and legacy mapping
    bus.OUT_READY = 1'b1;
    send(1'b1, MODE_LEGACY, 2'd1, 32'h44332211, 32'h33441122);
    chk("lat_after_accept_valid", bus.OUT_VALID, 0);
    @(posedge clk);
    #1;
    chk("lat_next_edge_valid", bus.OUT_VALID, 1);
    chk("lat_next_edge_data", bus.OUT_DATA, 32'h33441122);
    drain();

    // Mode table
    send(1'b1, MODE_ROT,    2'd1, 32'h44332211, 32'h11443322);
    send(1'b1, MODE_BCAST,  2'd2, 32'h44332211, 32'h33333333);
    send(1'b1, MODE_PASS,   2'd2, 32'h44332211, 32'h44332211);
    send(1'b1, MODE_LEGACY, 2'd3, 32'hA1B2C3D4, 32'hD4C3B2A1);
    send(1'b1, MODE_ROT,    2'd3, 32'hA1B2C3D4, 32'hB2C3D4A1);
    send(1'b1, MODE_BCAST,  2'd0, 32'hA1B2C3D4, 32'hD4D4D4D4);
    send(1'b1, MODE_LEGACY, 2'd0, 32'hA1B2C3D4, 32'hC3B2A1D4);
    drain();

    // SM_EN=0 zeroes only its own word
    send(1'b0, MODE_ROT,  2'd1, 32'h44332211, 32'h00000000);
    send(1'b1, MODE_PASS, 2'd0, 32'h55667788, 32'h55667788);
    drain();

    // Backpressure: credit stops at FIFO_DEPTH, drains in order
    bus.OUT_READY = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(1'b1, MODE_PASS, 2'd0, 32'h01020304, 32'h01020304);
        send(1'b1, MODE_PASS, 2'd1, 32'h11121314, 32'h11121314);
        send(1'b1, MODE_PASS, 2'd2, 32'h21222324, 32'h21222324);
        send(1'b1, MODE_PASS, 2'd3, 32'h31323334, 32'h31323334);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_accepted", acc_cnt - base, 3);
        chk("bp_req_ready_low", bus.REQ_READY, 0);
        chk("bp_head_valid", bus.OUT_VALID, 1);
        chk("bp_head_stable", bus.OUT_DATA, 32'h01020304);
        bus.OUT_READY = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_ready_after_pop", bus.REQ_READY, 1);
      end
    join
    drain();

    // Full-rate streaming
    pop_cyc_q.delete();
    drops = 0;
    stream_on = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b1, s_mode[i], s_sel[i], s_data[i], s_exp[i]);
    drain();
    stream_on = 1'b0;
    chk("stream_ready_drops", drops, 0);
    chk("stream_pop_count", pop_cyc_q.size(), 8);
    if (pop_cyc_q.size() == 8)
      chk("stream_pop_span", pop_cyc_q[7] - pop_cyc_q[0], 7);

    // Reset with work in flight and buffered
    bus.OUT_READY = 1'b0;
    send(1'b1, MODE_PASS, 2'd0, 32'h77777777, 32'h77777777);
    send(1'b1, MODE_PASS, 2'd0, 32'h88888888, 32'h88888888);
    send(1'b1, MODE_PASS, 2'd0, 32'h99999999, 32'h99999999);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.OUT_VALID, 0);
    chk("midrst_out_data", bus.OUT_DATA, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", bus.REQ_READY, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", bus.OUT_VALID, 0);
    end
    bus.OUT_READY = 1'b1;
    send(1'b1, MODE_ROT, 2'd3, 32'h0D0C0B0A, 32'h0C0B0A0D);
    @(posedge clk);
    #1;
    chk("midrst_first_data", bus.OUT_DATA, 32'h0C0B0A0D);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
